// File: rtl/line_pkg.sv
// Shared types and constants for the line-position error path.
// Latency: n/a (package). Backpressure: n/a.
// Weight shifts index R0..R3 then L0..L3; bit 2 of the index selects the left (subtracted) side.
package line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } err_state_t;

    localparam int IR_W     = 12;
    localparam int ERR_W    = 12;
    localparam int ACC_W    = 17;
    localparam int ERR_FRAC = 4;

    localparam logic [1:0] W_SHIFT [8] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                           2'd0, 2'd1, 2'd2, 2'd3};

    // One weighted term of the right-minus-left sum, sign applied.
    function automatic logic signed [ACC_W-1:0] wterm(input logic [IR_W-1:0] v,
                                                      input logic [2:0]      i);
        logic signed [ACC_W-1:0] mag;
        mag = $signed({{(ACC_W-IR_W){1'b0}}, v}) <<< W_SHIFT[i];
        return i[2] ? -mag : mag;
    endfunction

endpackage

// File: rtl/sat_sgn.sv
// Signed saturating narrower from IN_W to OUT_W bits.
// Latency: combinational. Backpressure: none.
// Values outside the OUT_W range clamp to the nearest representable extreme.
module sat_sgn #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAX_V) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (din < MIN_V) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/line_err.sv
// Snapshots eight IR readings per round and produces a saturated weighted position error.
// Latency: IR_vld to err_vld is 10 cycles. Backpressure: none; IR_vld outside IDLE is dropped.
// Line loss is flagged after LOST_RNDS consecutive line-absent rounds; error holds meanwhile.
module line_err
    import line_pkg::*;
#(
    parameter int unsigned LOST_RNDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IR_W-1:0]         IR_R0,
    input  logic [IR_W-1:0]         IR_R1,
    input  logic [IR_W-1:0]         IR_R2,
    input  logic [IR_W-1:0]         IR_R3,
    input  logic [IR_W-1:0]         IR_L0,
    input  logic [IR_W-1:0]         IR_L1,
    input  logic [IR_W-1:0]         IR_L2,
    input  logic [IR_W-1:0]         IR_L3,
    input  logic                    IR_vld,
    input  logic                    line_present,
    output logic signed [ERR_W-1:0] error,
    output logic                    err_vld,
    output logic                    line_lost
);

    localparam logic [3:0] LOST_THR = 4'(LOST_RNDS);

    err_state_t              state_q, state_d;
    logic [IR_W-1:0]         snap [8];
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] q;
    logic [2:0]              idx_q;
    logic [3:0]              lost_cnt_q, lost_inc;
    logic signed [ERR_W-1:0] err_sat;
    logic                    take;

    assign take     = (state_q == IDLE) && IR_vld;
    assign q        = acc_q >>> ERR_FRAC;
    assign lost_inc = (lost_cnt_q == 4'hF) ? 4'hF : lost_cnt_q + 4'd1;

    sat_sgn #(.IN_W(ACC_W), .OUT_W(ERR_W)) u_sat (
        .din  (q),
        .dout (err_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (IR_vld) state_d = ACCUM;
            ACCUM:   if (idx_q == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot needs no reset: it is always loaded before it is read.
    always_ff @(posedge clk) begin
        if (take) begin
            snap <= '{IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            idx_q      <= '0;
            lost_cnt_q <= '0;
            error      <= '0;
            err_vld    <= 1'b0;
            line_lost  <= 1'b0;
        end else begin
            err_vld <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (IR_vld) begin
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + wterm(snap[idx_q], idx_q);
                    idx_q <= idx_q + 3'd1;
                end
                DONE: begin
                    err_vld <= 1'b1;
                    if (line_present) begin
                        error      <= err_sat;
                        lost_cnt_q <= '0;
                        line_lost  <= 1'b0;
                    end else begin
                        lost_cnt_q <= lost_inc;
                        if (lost_inc >= LOST_THR) line_lost <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_err.sv
// Randomized self-checking bench for line_err against an arithmetic reference model.
// Each round is tracked cycle by cycle; err_vld is expected only 10 cycles after IR_vld.
module tb_line_err;

    localparam int LOST = 4;

    typedef logic [11:0] vec_t [8];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] ir [8];
    logic        IR_vld;
    logic        line_present;
    logic [11:0] error;
    logic        err_vld;
    logic        line_lost;

    int          n_chk  = 0;
    int          n_pass = 0;

    logic [11:0] m_err  = 12'h000;
    int          m_cnt  = 0;
    bit          m_lost = 1'b0;

    always #5 clk = ~clk;

    line_err #(.LOST_RNDS(LOST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IR_R0        (ir[0]),
        .IR_R1        (ir[1]),
        .IR_R2        (ir[2]),
        .IR_R3        (ir[3]),
        .IR_L0        (ir[4]),
        .IR_L1        (ir[5]),
        .IR_L2        (ir[6]),
        .IR_L3        (ir[7]),
        .IR_vld       (IR_vld),
        .line_present (line_present),
        .error        (error),
        .err_vld      (err_vld),
        .line_lost    (line_lost)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      tag, obs, obs, exp, exp, $time);
    endtask

    // Weighted right-minus-left sum, divided by 16 with floor, clamped to 12-bit signed.
    function automatic logic [11:0] ref_err(input vec_t v);
        int acc = 0;
        int q;
        for (int i = 0; i < 4; i++) begin
            acc += int'(v[i]) * (1 << i);
            acc -= int'(v[i+4]) * (1 << i);
        end
        q = (acc >= 0) ? acc / 16 : -((-acc + 15) / 16);
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return 12'(q);
    endfunction

    function automatic logic [11:0] rnd12();
        case ($urandom_range(0, 3))
            0:       return 12'h000;
            1:       return 12'hFFF;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    // mode 0: plain, 1: extra IR_vld at T+4, 2: inputs churn during ACCUM, 3: reset at T+5
    task automatic run_round(input vec_t v, input bit lp, input int mode);
        logic [11:0] exp_new;
        bit          aborted = 1'b0;
        exp_new = ref_err(v);
        @(negedge clk);
        ir           = v;
        line_present = lp;
        IR_vld       = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 10 && !aborted) begin
                if (lp) begin
                    m_err  = exp_new;
                    m_cnt  = 0;
                    m_lost = 1'b0;
                end else begin
                    m_cnt  = (m_cnt < 15) ? m_cnt + 1 : 15;
                    m_lost = (m_cnt >= LOST);
                end
            end
            check("err_vld",   int'(err_vld),   int'(c == 10 && !aborted));
            check("error",     int'(error),     int'(m_err));
            check("line_lost", int'(line_lost), int'(m_lost));
            IR_vld = 1'b0;
            if (mode == 1 && c == 4) begin
                for (int k = 0; k < 8; k++) ir[k] = rnd12();
                IR_vld = 1'b1;
            end
            if (mode == 2 && c <= 8) begin
                for (int k = 0; k < 8; k++) ir[k] = rnd12();
            end
            if (mode == 3 && c == 5) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
                m_err   = 12'h000;
                m_cnt   = 0;
                m_lost  = 1'b0;
            end
            if (mode == 3 && c == 7) rst_n = 1'b1;
        end
    endtask

    initial begin
        vec_t v;
        rst_n        = 1'b0;
        IR_vld       = 1'b0;
        line_present = 1'b0;
        for (int k = 0; k < 8; k++) ir[k] = 12'h000;
        repeat (3) @(negedge clk);
        check("rst_error",     int'(error),     0);
        check("rst_err_vld",   int'(err_vld),   0);
        check("rst_line_lost", int'(line_lost), 0);
        rst_n = 1'b1;

        // R3 = 0x100 -> +128
        v = '{default: 12'h000}; v[3] = 12'h100;
        run_round(v, 1'b1, 0);
        // L3 full scale -> floor(-2047.5) = -2048
        v = '{default: 12'h000}; v[7] = 12'hFFF;
        run_round(v, 1'b1, 0);
        // right side full -> clamp +2047, then left side full -> clamp -2048
        v = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};
        run_round(v, 1'b1, 0);
        v = '{12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        run_round(v, 1'b1, 0);
        // balanced inputs -> zero
        v = '{default: 12'h555};
        run_round(v, 1'b1, 0);
        // establish a non-zero error, then lose the line for LOST+1 rounds and recover
        v = '{default: 12'h000}; v[2] = 12'h321;
        run_round(v, 1'b1, 0);
        for (int r = 0; r < LOST + 1; r++) begin
            for (int k = 0; k < 8; k++) v[k] = rnd12();
            run_round(v, 1'b0, 0);
        end
        for (int k = 0; k < 8; k++) v[k] = rnd12();
        run_round(v, 1'b1, 0);
        // ignored second IR_vld, input churn, mid-round reset, then a clean round
        for (int m = 1; m <= 3; m++) begin
            for (int k = 0; k < 8; k++) v[k] = rnd12();
            run_round(v, 1'b1, m);
        end
        v = '{default: 12'h000}; v[0] = 12'h7F0;
        run_round(v, 1'b1, 0);

        for (int r = 0; r < 60; r++) begin
            int mode;
            for (int k = 0; k < 8; k++) v[k] = rnd12();
            mode = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3);
            run_round(v, ($urandom_range(0, 3) != 0), mode);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/line_err.md
# line_err

Downstream consumer of the IR sensor interface: on each completed sensor round it snapshots the eight 12-bit IR readings, forms a signed position error by a weighted right-minus-left sum, and presents a saturated 12-bit error with a one-cycle valid strobe to the steering controller. It also tracks consecutive rounds without a line and flags line loss, holding the last good error while the line is absent.

## Interface
- `LOST_RNDS`, 4: consecutive line-absent rounds (1..15) before `line_lost` asserts.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `IR_R0`..`IR_R3` in 12 each: right sensor readings, unsigned.
- `IR_L0`..`IR_L3` in 12 each: left sensor readings, unsigned.
- `IR_vld` in 1: one-cycle pulse, all eight readings valid this cycle.
- `line_present` in 1: registered line-detect flag; valid from the cycle after `IR_vld`.
- `error` out 12: signed saturated error; positive = line to the right.
- `err_vld` out 1: one-cycle pulse, `error` updated.
- `line_lost` out 1: high after `LOST_RNDS` consecutive line-absent rounds.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: on `IR_vld`, load the eight readings into snapshot regs, clear 17-bit signed accumulator `acc`, clear 3-bit index `idx`, go ACCUM.
- ACCUM: one term per cycle, index order R0,R1,R2,R3,L0,L1,L2,L3. Weights: R0 +1, R1 +2, R2 +4, R3 +8, L0 −1, L1 −2, L2 −4, L3 −8, implemented as shifts, zero-extended before add/sub. `idx` increments each cycle; after the idx=7 add, go DONE.
- `acc` range ±61425; 17 bits signed, never overflows.
- DONE: `q = acc >>> 4` (arithmetic, floor). Saturate `q` to [−2048, +2047].
  - If `line_present`=1: `error` <= saturated q, clear lost counter, `line_lost` <= 0.
  - If `line_present`=0: `error` holds; lost counter increments, saturating at 15; `line_lost` <= 1 when the counter reaches `LOST_RNDS`.
  - `err_vld` <= 1 in both cases. Return to IDLE.
- `IR_vld` outside IDLE is ignored. No new snapshot is taken and the current round completes unchanged.
- Reset values: `error`=0, `err_vld`=0, `line_lost`=0, state IDLE, acc/idx/lost counter=0, snapshot regs don't-care.
- Reset mid-round aborts the round. No `err_vld` is produced for it.

## Timing
- Cycle T: `IR_vld` high; snapshot captured at the edge ending T.
- Cycles T+1..T+8: ACCUM, one term each.
- Cycle T+9: DONE. `line_present` is sampled here, which satisfies its one-cycle lag.
- Cycle T+10: `err_vld` high for exactly one cycle, with the new `error`/`line_lost` visible.
- Latency from `IR_vld` to `err_vld` is 10 cycles.
- Minimum `IR_vld` spacing is 10 cycles; the upstream round period far exceeds this.
- `IR_vld` arriving in cycle T+10 is accepted (state is IDLE).
- `error` and `line_lost` are stable between `err_vld` pulses.

## Structure
- Shared package `line_pkg`:
  - `err_state_t` enum (IDLE, ACCUM, DONE).
  - `ERR_W`=12, `ACC_W`=17.
  - Weight shift constants.
- Sub-module `sat_sgn`: parameterised signed saturator from width IN_W to OUT_W. Used for the 17→12 clamp and reusable by the PID stage.
- All outputs come directly from flops.

## Test plan
- Reset, then R3=0x100 and all others 0, pulse `IR_vld`, `line_present`=1 → exactly 10 cycles later `err_vld` pulses once, `error`=0x080 (+128).
- L3=0xFFF and others 0 → `error`=0x800 (acc −32760, floor −2047.5 → −2048).
- R0..R3=0xFFF and L=0 → acc 61425, q 3839, `error`=0x7FF saturated. Mirror case (L all 0xFFF) → 0x800.
- All inputs equal 0x555 → `error`=0x000.
- `line_present`=0 for rounds 1..4 with `LOST_RNDS`=4 → `error` holds its prior value, `err_vld` pulses each round, `line_lost` rises at the 4th `err_vld`. Next round with `line_present`=1 → `line_lost`=0 and `error` updates.
- Second `IR_vld` at T+4 → ignored, single `err_vld` at T+10 computed from the T snapshot.
- Changing IR inputs during ACCUM → no effect on the result.
- Assert `rst_n` low at T+5 → all outputs 0 and no `err_vld`. A new `IR_vld` after reset produces a correct result.
